// File: rtl/updown_counter.sv
module updown_counter #(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] MAX_VAL = '1,
  parameter int unsigned      MODE    = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             evt,
  output logic             busy,
  output logic             done,
  output logic             start,
  output logic             start_delayed
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             evt_nxt;
  logic             at_bound;

  always_comb begin
    at_bound  = up ? (q == MAX_VAL) : (q == '0);
    tc        = en & at_bound & (state != DONE);
    start     = en;
    busy      = (state == RUN);
    done      = (state == DONE);

    q_nxt     = q;
    state_nxt = state;
    evt_nxt   = 1'b0;

    if (clr) begin
      q_nxt     = '0;
      state_nxt = IDLE;
    end else if (load) begin
      q_nxt     = (load_val > MAX_VAL) ? MAX_VAL : load_val;
      state_nxt = IDLE;
    end else if (en && (state != DONE)) begin
      state_nxt = RUN;
      if (!at_bound) begin
        q_nxt = up ? q + 1'b1 : q - 1'b1;
      end else begin
        evt_nxt = 1'b1;
        if (MODE == 0) begin
          q_nxt = up ? '0 : MAX_VAL;
        end else if (MODE == 1) begin
          q_nxt = q;
        end else begin
          q_nxt     = q;
          state_nxt = DONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      q             <= '0;
      evt           <= 1'b0;
      start_delayed <= 1'b0;
      state         <= IDLE;
    end else begin
      q             <= q_nxt;
      evt           <= evt_nxt;
      start_delayed <= start;
      state         <= state_nxt;
    end
  end

`ifdef UPDOWN_COUNTER_CHECKERS_EN
  logic chk_init = 1'b0;

  always_ff @(posedge clk) begin
    chk_init <= 1'b1;
  end

  a_rst_init: assume property (@(posedge clk) !chk_init |-> !rstn);

  p_q_range: assert property (@(posedge clk) disable iff (!rstn)
    q <= MAX_VAL);
  c_q_range: cover property (@(posedge clk) disable iff (!rstn)
    q == MAX_VAL);

  p_hold: assert property (@(posedge clk) disable iff (!rstn)
    (!en && !clr && !load) |=> $stable(q));
  c_hold: cover property (@(posedge clk) disable iff (!rstn)
    (!en && !clr && !load));

  p_inc: assert property (@(posedge clk) disable iff (!rstn)
    (en && up && (q < MAX_VAL) && !clr && !load && (state != DONE))
    |=> (q == $past(q) + 1'b1));
  c_inc: cover property (@(posedge clk) disable iff (!rstn)
    (en && up && (q < MAX_VAL) && !clr && !load && (state != DONE)));

  p_dec: assert property (@(posedge clk) disable iff (!rstn)
    (en && !up && (q > '0) && !clr && !load && (state != DONE))
    |=> (q == $past(q) - 1'b1));
  c_dec: cover property (@(posedge clk) disable iff (!rstn)
    (en && !up && (q > '0) && !clr && !load && (state != DONE)));

  p_start: assert property (@(posedge clk) disable iff (!rstn)
    en |-> start);
  c_start: cover property (@(posedge clk) disable iff (!rstn) en);

  p_start_dly: assert property (@(posedge clk) disable iff (!rstn)
    start |=> start_delayed);
  c_start_dly: cover property (@(posedge clk) disable iff (!rstn)
    start ##1 start_delayed);

  p_evt: assert property (@(posedge clk) disable iff (!rstn)
    (tc && !clr && !load) |=> evt);
  c_evt: cover property (@(posedge clk) disable iff (!rstn)
    (tc && !clr && !load) ##1 evt);

  p_done_frozen: assert property (@(posedge clk) disable iff (!rstn)
    (done && !clr && !load) |=> $stable(q));
  c_done_frozen: cover property (@(posedge clk) disable iff (!rstn)
    done);
`endif

endmodule

// File: tb/tb_updown_counter.sv
// Testbench for updown_counter: three instances (wrap/saturate/one-shot)
// share one stimulus stream; each is compared against a behavioural model.

module tb_updown_counter;

    logic       clk = 1'b0;
    logic       rstn;
    logic       en;
    logic       up;
    logic       clr;
    logic       load;
    logic [3:0] load_val;

    logic [3:0] q_o   [3];
    logic       tc_o  [3];
    logic       evt_o [3];
    logic       busy_o[3];
    logic       done_o[3];
    logic       st_o  [3];
    logic       sd_o  [3];

    int checks = 0;
    int errors = 0;

    // Reference model state per instance
    int mq  [3];
    int mst [3];   // 0 idle, 1 running, 2 finished
    int mevt[3];
    int msd;
    bit mvalid = 1'b0;
    int mmax [3] = '{9, 9, 5};
    int mmode[3] = '{0, 1, 2};

    always #5 clk = ~clk;

    updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .MODE(0)) u_wrap (
        .clk(clk), .rstn(rstn), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .q(q_o[0]), .tc(tc_o[0]), .evt(evt_o[0]),
        .busy(busy_o[0]), .done(done_o[0]), .start(st_o[0]),
        .start_delayed(sd_o[0]));

    updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .MODE(1)) u_sat (
        .clk(clk), .rstn(rstn), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .q(q_o[1]), .tc(tc_o[1]), .evt(evt_o[1]),
        .busy(busy_o[1]), .done(done_o[1]), .start(st_o[1]),
        .start_delayed(sd_o[1]));

    updown_counter #(.WIDTH(4), .MAX_VAL(4'd5), .MODE(2)) u_once (
        .clk(clk), .rstn(rstn), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .q(q_o[2]), .tc(tc_o[2]), .evt(evt_o[2]),
        .busy(busy_o[2]), .done(done_o[2]), .start(st_o[2]),
        .start_delayed(sd_o[2]));

    task automatic chk(input string tag, input int i,
                       input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d]: got %0d expected %0d", tag, i, obs, exp);
        end
    endtask

    function automatic int model_tc(input int i);
        int hit;
        hit = up ? (mq[i] == mmax[i]) : (mq[i] == 0);
        return (en && hit && mst[i] != 2) ? 1 : 0;
    endfunction

    // Applies one clock edge's worth of behaviour from the current inputs.
    task automatic model_update();
        for (int i = 0; i < 3; i++) begin
            if (!rstn) begin
                mq[i] = 0; mst[i] = 0; mevt[i] = 0;
            end else if (clr) begin
                mq[i] = 0; mst[i] = 0; mevt[i] = 0;
            end else if (load) begin
                mq[i] = (int'(load_val) > mmax[i]) ? mmax[i] : int'(load_val);
                mst[i] = 0; mevt[i] = 0;
            end else if (en && mst[i] != 2) begin
                mst[i] = 1; mevt[i] = 0;
                if (up && mq[i] < mmax[i]) mq[i] = mq[i] + 1;
                else if (!up && mq[i] > 0) mq[i] = mq[i] - 1;
                else begin
                    mevt[i] = 1;
                    if (mmode[i] == 0) mq[i] = up ? 0 : mmax[i];
                    else if (mmode[i] == 2) mst[i] = 2;
                end
            end else begin
                mevt[i] = 0;
            end
        end
        msd = rstn ? int'(en) : 0;
        if (!rstn) mvalid = 1'b1;
    endtask

    // Inputs are driven before the call (away from posedge).
    task automatic cycle();
        #1;
        for (int i = 0; i < 3; i++) chk("start", i, st_o[i], en);
        if (mvalid)
            for (int i = 0; i < 3; i++) chk("tc", i, tc_o[i], model_tc(i));
        @(posedge clk);
        model_update();
        #1;
        if (mvalid) begin
            for (int i = 0; i < 3; i++) begin
                chk("q", i, q_o[i], mq[i]);
                chk("evt", i, evt_o[i], mevt[i]);
                chk("busy", i, busy_o[i], (mst[i] == 1) ? 1 : 0);
                chk("done", i, done_o[i], (mst[i] == 2) ? 1 : 0);
                chk("start_delayed", i, sd_o[i], msd);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rstn = 1'b0; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0;
        load_val = '0;
        cycle(); cycle();
        chk("reset_q", 0, q_o[0], 0);
        rstn = 1'b1;

        // Count up through the terminal value.
        en = 1'b1; up = 1'b1;
        repeat (12) cycle();
        chk("wrap_q_after12", 0, q_o[0], 2);
        chk("oneshot_done", 2, done_o[2], 1);

        // Saturate on the way down.
        en = 1'b0; load = 1'b1; load_val = 4'd2; cycle();
        load = 1'b0; en = 1'b1; up = 1'b0;
        repeat (5) cycle();
        chk("sat_q_floor", 1, q_o[1], 0);
        chk("sat_evt_held", 1, evt_o[1], 1);

        // One-shot run to completion, then load leaves DONE.
        rstn = 1'b0; en = 1'b0; cycle();
        rstn = 1'b1; en = 1'b1; up = 1'b1;
        repeat (8) cycle();
        chk("oneshot_frozen", 2, q_o[2], 5);
        en = 1'b0; load = 1'b1; load_val = 4'd3; cycle();
        load = 1'b0;
        chk("oneshot_reload", 2, q_o[2], 3);

        // Load clamping and clr/load/en together.
        load = 1'b1; load_val = 4'd15; cycle();
        chk("load_clamp", 0, q_o[0], 9);
        clr = 1'b1; load = 1'b1; en = 1'b1; load_val = 4'd6; cycle();
        chk("clr_priority", 0, q_o[0], 0);
        clr = 1'b0; load = 1'b0; en = 1'b0; cycle();

        // Reset mid-count.
        en = 1'b1; up = 1'b1;
        repeat (7) cycle();
        chk("count_to_7", 0, q_o[0], 7);
        rstn = 1'b0; cycle();
        rstn = 1'b1; en = 1'b0; cycle();

        // Enable toggling.
        en = 1'b1; cycle();
        en = 1'b0; cycle(); cycle();
        en = 1'b1; cycle();
        en = 1'b0; cycle();

        // Randomised traffic.
        repeat (400) begin
            rstn     = ($urandom_range(0, 49) != 0);
            clr      = ($urandom_range(0, 19) == 0);
            load     = ($urandom_range(0, 11) == 0);
            en       = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 5) == 0) up = ~up;
            load_val = 4'($urandom_range(0, 15));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
